// File: rtl/usbdev_pkg.sv
// Shared types and widths for the usbdev packet-buffer SRAM path.
package usbdev_pkg;

  localparam int unsigned UsbdevSramAw = 9;
  localparam int unsigned UsbdevSramDw = 32;
  localparam int unsigned UsbdevSramMw = UsbdevSramDw / 8;

  typedef struct packed {
    logic                    write;
    logic [UsbdevSramAw-1:0] addr;
    logic [UsbdevSramDw-1:0] wdata;
    logic [UsbdevSramMw-1:0] wmask;
  } usbdev_mem_req_t;

endpackage

// File: rtl/usbdev_mem_arb.sv
// Packet-buffer SRAM arbiter: USB side has absolute priority, bus side goes
// through a one-entry hold register with a starvation event.
module usbdev_mem_arb
  import usbdev_pkg::*;
#(
  parameter int unsigned SramAw  = UsbdevSramAw,
  parameter int unsigned SramDw  = UsbdevSramDw,
  parameter int unsigned MaxWait = 16
) (
  input  logic                clk_48mhz_i,
  input  logic                rst_i,
  input  logic                usb_req_i,
  input  logic                usb_write_i,
  input  logic [SramAw-1:0]   usb_addr_i,
  input  logic [SramDw-1:0]   usb_wdata_i,
  output logic [SramDw-1:0]   usb_rdata_o,
  input  logic                bus_req_i,
  output logic                bus_gnt_o,
  input  logic                bus_write_i,
  input  logic [SramAw-1:0]   bus_addr_i,
  input  logic [SramDw-1:0]   bus_wdata_i,
  input  logic [SramDw/8-1:0] bus_wmask_i,
  output logic                bus_rvalid_o,
  output logic [SramDw-1:0]   bus_rdata_o,
  output logic                sram_req_o,
  output logic                sram_write_o,
  output logic [SramAw-1:0]   sram_addr_o,
  output logic [SramDw-1:0]   sram_wdata_o,
  output logic [SramDw/8-1:0] sram_wmask_o,
  input  logic [SramDw-1:0]   sram_rdata_i,
  output logic                starve_o
);

  localparam int unsigned SramMw = SramDw / 8;
  localparam logic [7:0]  WaitMax = 8'(MaxWait);

  // Hold register uses the package struct, so SramAw/SramDw must not exceed its widths.
  usbdev_mem_req_t hold_q;
  logic            hold_valid;
  logic [7:0]      wait_cnt;
  logic            starve_q;
  logic            rsp_pending;
  logic            rsp_is_read;
  logic            issue_bus;
  logic            accept;

  assign bus_gnt_o = ~hold_valid;
  assign accept    = bus_req_i & bus_gnt_o;

  always_comb begin
    sram_req_o   = 1'b0;
    sram_write_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    issue_bus    = 1'b0;
    if (usb_req_i) begin
      sram_req_o   = 1'b1;
      sram_write_o = usb_write_i;
      sram_addr_o  = usb_addr_i;
      sram_wdata_o = usb_wdata_i;
      sram_wmask_o = '1;
    end else if (hold_valid) begin
      issue_bus    = 1'b1;
      sram_req_o   = 1'b1;
      sram_write_o = hold_q.write;
      sram_addr_o  = SramAw'(hold_q.addr);
      sram_wdata_o = SramDw'(hold_q.wdata);
      sram_wmask_o = SramMw'(hold_q.wmask);
    end
  end

  always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid  <= 1'b0;
      hold_q      <= '0;
      wait_cnt    <= '0;
      starve_q    <= 1'b0;
      rsp_pending <= 1'b0;
      rsp_is_read <= 1'b0;
    end else begin
      starve_q    <= 1'b0;
      rsp_pending <= issue_bus;
      rsp_is_read <= issue_bus & ~hold_q.write;
      // Accept and issue are mutually exclusive: issue needs hold_valid, accept needs it clear.
      if (accept) begin
        hold_valid   <= 1'b1;
        hold_q.write <= bus_write_i;
        hold_q.addr  <= UsbdevSramAw'(bus_addr_i);
        hold_q.wdata <= UsbdevSramDw'(bus_wdata_i);
        hold_q.wmask <= UsbdevSramMw'(bus_wmask_i);
      end else if (issue_bus) begin
        hold_valid <= 1'b0;
      end
      if (issue_bus) begin
        wait_cnt <= '0;
      end else if (hold_valid && usb_req_i && (wait_cnt != WaitMax)) begin
        wait_cnt <= wait_cnt + 8'd1;
        starve_q <= (wait_cnt == WaitMax - 8'd1);
      end
    end
  end

  assign bus_rvalid_o = rsp_pending;
  assign bus_rdata_o  = rsp_is_read ? sram_rdata_i : '0;
  assign usb_rdata_o  = sram_rdata_i;
  assign starve_o     = starve_q;

endmodule

// File: tb/tb_usbdev_mem_arb.sv
// Directed bench for usbdev_mem_arb with a behavioural 1-cycle-latency SRAM.
module tb_usbdev_mem_arb;

  logic        clk;
  logic        rst;
  logic        usb_req, usb_write;
  logic [8:0]  usb_addr;
  logic [31:0] usb_wdata, usb_rdata;
  logic        bus_req, bus_gnt, bus_write;
  logic [8:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        sram_req, sram_write;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_rdata;
  logic        starve;

  int checks   = 0;
  int failures = 0;
  int usb_run  = 0;

  logic [31:0] mem [512];

  usbdev_mem_arb #(.SramAw(9), .SramDw(32), .MaxWait(16)) dut (
    .clk_48mhz_i (clk),
    .rst_i       (rst),
    .usb_req_i   (usb_req),
    .usb_write_i (usb_write),
    .usb_addr_i  (usb_addr),
    .usb_wdata_i (usb_wdata),
    .usb_rdata_o (usb_rdata),
    .bus_req_i   (bus_req),
    .bus_gnt_o   (bus_gnt),
    .bus_write_i (bus_write),
    .bus_addr_i  (bus_addr),
    .bus_wdata_i (bus_wdata),
    .bus_wmask_i (bus_wmask),
    .bus_rvalid_o(bus_rvalid),
    .bus_rdata_o (bus_rdata),
    .sram_req_o  (sram_req),
    .sram_write_o(sram_write),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_wmask_o(sram_wmask),
    .sram_rdata_i(sram_rdata),
    .starve_o    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: contents restored to A000_0000 + addr on every reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      sram_rdata <= '0;
    end else if (sram_req) begin
      if (sram_write) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (usb_req) usb_run <= usb_run + 1;
    else         usb_run <= 0;
    assert (usb_run <= 32) else begin
      failures++;
      $error("FAIL usb_run observed=%0d expected<=32", usb_run);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    usb_req = 0; usb_write = 0; usb_addr = '0; usb_wdata = '0;
    bus_req = 0; bus_write = 0; bus_addr = '0; bus_wdata = '0; bus_wmask = '0;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [8:0]  a;
    int          gnts, rvs;

    rst = 1'b1;
    idle();
    step();
    chk("rst_gnt", bus_gnt, 1);
    chk("rst_rvalid", bus_rvalid, 0);
    chk("rst_starve", starve, 0);
    chk("rst_sram_req", sram_req, 0);
    rst = 1'b0;
    step();

    // Bus read with USB idle
    bus_req = 1; bus_write = 0; bus_addr = 9'd7;
    #1; chk("rd_gnt", bus_gnt, 1); chk("rd_noissue_c0", sram_req, 0);
    step(); bus_req = 0;
    #1; chk("rd_issue", sram_req, 1); chk("rd_issue_we", sram_write, 0);
    chk("rd_issue_addr", sram_addr, 7); chk("rd_gnt_c1", bus_gnt, 0); chk("rd_rvalid_c1", bus_rvalid, 0);
    step();
    #1; chk("rd_rvalid", bus_rvalid, 1); chk("rd_rdata", bus_rdata, 32'hA000_0007); chk("rd_gnt_c2", bus_gnt, 1);
    step();
    #1; chk("rd_rvalid_c3", bus_rvalid, 0);

    // USB writes addr 5 for 4 cycles; bus read of addr 5 waits
    usb_req = 1; usb_write = 1; usb_addr = 9'd5; usb_wdata = 32'h1111_0000;
    bus_req = 1; bus_write = 0; bus_addr = 9'd5;
    #1; chk("pri_gnt", bus_gnt, 1); chk("pri_we", sram_write, 1);
    chk("pri_mask", sram_wmask, 4'hF); chk("pri_addr", sram_addr, 5); chk("pri_wdata", sram_wdata, 32'h1111_0000);
    step(); bus_req = 0;
    for (int k = 1; k < 4; k++) begin
      usb_wdata = 32'h1111_0000 | 32'(k);
      #1; chk("pri_gnt_busy", bus_gnt, 0); chk("pri_usb_wins", sram_write, 1);
      step();
    end
    usb_req = 0; usb_write = 0;
    #1; chk("pri_issue", sram_req, 1); chk("pri_issue_we", sram_write, 0);
    chk("pri_issue_addr", sram_addr, 5); chk("pri_starve", starve, 0);
    step();
    #1; chk("pri_rvalid", bus_rvalid, 1); chk("pri_rdata", bus_rdata, 32'h1111_0003);
    usb_req = 1; usb_addr = 9'd5;
    step(); usb_req = 0;
    #1; chk("usb_rdata", usb_rdata, 32'h1111_0003); chk("usb_rd_no_rvalid", bus_rvalid, 0);
    step();

    // Held bus write, then USB read of the same address sees old data
    bus_req = 1; bus_write = 1; bus_addr = 9'd9; bus_wdata = 32'h1234_5678; bus_wmask = 4'hF;
    step(); bus_req = 0;
    usb_req = 1; usb_write = 0; usb_addr = 9'd9;
    #1; chk("ord_usb_read", sram_write, 0); chk("ord_gnt", bus_gnt, 0);
    step(); usb_req = 0;
    #1; chk("ord_old_data", usb_rdata, 32'hA000_0009); chk("ord_issue_we", sram_write, 1);
    chk("ord_issue_addr", sram_addr, 9);
    step();
    #1; chk("ord_rvalid", bus_rvalid, 1); chk("ord_wr_rdata", bus_rdata, 0);
    usb_req = 1; usb_addr = 9'd9;
    step(); usb_req = 0;
    #1; chk("ord_new_data", usb_rdata, 32'h1234_5678);
    step();

    // Byte-masked bus write
    bus_req = 1; bus_write = 1; bus_addr = 9'd3; bus_wdata = 32'hDEAD_BEEF; bus_wmask = 4'b0011;
    step(); bus_req = 0;
    #1; chk("msk_we", sram_write, 1); chk("msk_mask", sram_wmask, 4'b0011);
    chk("msk_wdata", sram_wdata, 32'hDEAD_BEEF); chk("msk_addr", sram_addr, 3);
    step();
    #1; chk("msk_rvalid", bus_rvalid, 1); chk("msk_rdata", bus_rdata, 0);
    usb_req = 1; usb_write = 0; usb_addr = 9'd3;
    step(); usb_req = 0;
    #1; chk("msk_mem", usb_rdata, 32'hA000_BEEF);
    step();

    // Starvation: USB busy 16 cycles while a bus read is held
    bus_req = 1; bus_write = 0; bus_addr = 9'd1;
    #1; chk("stv_gnt", bus_gnt, 1);
    step(); bus_req = 0;
    usb_req = 1; usb_write = 0; usb_addr = 9'd0;
    for (int k = 1; k <= 16; k++) begin
      #1; chk("stv_quiet", starve, 0); chk("stv_held", bus_gnt, 0);
      step();
    end
    usb_req = 0;
    #1; chk("stv_pulse", starve, 1); chk("stv_issue", sram_req, 1); chk("stv_issue_addr", sram_addr, 1);
    step();
    #1; chk("stv_once", starve, 0); chk("stv_rvalid", bus_rvalid, 1); chk("stv_rdata", bus_rdata, 32'hA000_0001);
    step();

    // Reset while a bus write is held
    bus_req = 1; bus_write = 1; bus_addr = 9'd2; bus_wdata = 32'hFFFF_FFFF; bus_wmask = 4'hF;
    step(); bus_req = 0;
    usb_req = 1; usb_write = 0; usb_addr = 9'd0;
    #1; chk("rst_mid_held", bus_gnt, 0);
    rst = 1'b1;
    #1; chk("rst_mid_gnt", bus_gnt, 1);
    usb_req = 0;
    #1; chk("rst_mid_noissue", sram_req, 0);
    step(); rst = 1'b0;
    #1; chk("rst_rel_rvalid", bus_rvalid, 0); chk("rst_rel_sram", sram_req, 0); chk("rst_rel_gnt", bus_gnt, 1);
    step();
    #1; chk("rst_rel_rvalid2", bus_rvalid, 0); chk("rst_rel_mem", mem[2], 32'hA000_0002);

    // Back-to-back bus reads with USB idle
    gnts = 0; rvs = 0; a = 9'd16;
    bus_req = 1; bus_write = 0; bus_addr = a;
    for (int k = 0; k < 10; k++) begin
      #1; chk("b2b_gnt", bus_gnt, (k % 2) == 0);
      if (bus_rvalid) begin
        rvs++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        chk("b2b_rdata", bus_rdata, e);
      end
      if (bus_gnt) begin
        gnts++;
        exp_q.push_back(32'hA000_0000 | 32'(a));
        a = a + 9'd1;
      end
      step();
      bus_addr = a;
    end
    bus_req = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus_rvalid) begin
        rvs++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        chk("b2b_rdata_tail", bus_rdata, e);
      end
      step();
    end
    chk("b2b_gnt_count", gnts, 5);
    chk("b2b_rvalid_count", rvs, gnts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
